// File: rtl/light_monitor.sv
// light_monitor: watches a two-road traffic lamp bus once per second,
// decodes the lamp pattern into a phase, tracks how long the pattern has
// been held and raises conflict / illegal / sequence / stuck faults.
// Every output is registered and describes the sample taken at the
// previous rising edge of clk_1Hz.
// Optional build macro: LIGHT_MONITOR_FAULT_LATCH_EN makes every fault
// bit sticky until reset; without it faults follow the latest sample.
module light_monitor #(
    parameter int YEL_MIN   = 3,
    parameter int STUCK_MAX = 60
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic [5:0] light,
    output logic [2:0] phase,
    output logic [7:0] dwell,
    output logic       change,
    output logic [3:0] fault,
    output logic       safe_red
);

    typedef enum logic [2:0] {
        PH_NS_GRN  = 3'd0,
        PH_NS_YEL  = 3'd1,
        PH_EW_GRN  = 3'd2,
        PH_EW_YEL  = 3'd3,
        PH_ALL_RED = 3'd4,
        PH_INVALID = 3'd7
    } phase_t;

    // A yellow must have been held for YEL_MIN samples, i.e. its dwell
    // register (which excludes the first sample) must reach YEL_MIN-1.
    localparam logic [7:0] YEL_HOLD  = 8'(YEL_MIN - 1);
    localparam logic [7:0] STUCK_LIM = 8'(STUCK_MAX);

    // Registered state
    phase_t     phase_q;
    logic [5:0] prev_light_q;
    logic       prev_valid_q;
    logic [7:0] dwell_q;
    logic       change_q;
    logic [3:0] fault_q;
    logic       safe_q;

    // Next-state values
    phase_t     phase_d;
    logic [7:0] dwell_d;
    logic       change_d;
    logic [3:0] fault_d;
    logic       safe_d;
    logic       conflict;
    logic       illegal;
    logic       seq_err;
    logic       stuck;
    logic       yel_short;
    logic       both_legal;

    function automatic phase_t decode(input logic [5:0] l);
        phase_t p;
        case (l)
            6'b001100: p = PH_NS_GRN;
            6'b010100: p = PH_NS_YEL;
            6'b100001: p = PH_EW_GRN;
            6'b100010: p = PH_EW_YEL;
            6'b100100: p = PH_ALL_RED;
            default:   p = PH_INVALID;
        endcase
        return p;
    endfunction

    function automatic logic permitted(input phase_t from_ph, input phase_t to_ph);
        logic ok;
        ok = 1'b0;
        case (from_ph)
            PH_NS_GRN:  ok = (to_ph == PH_NS_YEL);
            PH_NS_YEL:  ok = (to_ph == PH_EW_GRN) || (to_ph == PH_ALL_RED);
            PH_EW_GRN:  ok = (to_ph == PH_EW_YEL);
            PH_EW_YEL:  ok = (to_ph == PH_NS_GRN) || (to_ph == PH_ALL_RED);
            PH_ALL_RED: ok = (to_ph == PH_NS_GRN) || (to_ph == PH_EW_GRN);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Decode the current sample and derive every next output value
    always_comb begin
        phase_d    = decode(light);
        change_d   = prev_valid_q && (light != prev_light_q);
        dwell_d    = '0;
        yel_short  = 1'b0;
        seq_err    = 1'b0;

        if (prev_valid_q && !change_d) begin
            dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        end

        conflict   = !light[5] && !light[2];
        illegal    = (phase_d == PH_INVALID) && !conflict;
        both_legal = prev_valid_q && (phase_q != PH_INVALID) && (phase_d != PH_INVALID);

        if (both_legal && (phase_d != phase_q)) begin
            yel_short = ((phase_q == PH_NS_YEL) || (phase_q == PH_EW_YEL)) &&
                        (dwell_q < YEL_HOLD);
            seq_err   = !permitted(phase_q, phase_d) || yel_short;
        end

        stuck = (dwell_d >= STUCK_LIM);

`ifdef LIGHT_MONITOR_FAULT_LATCH_EN
        fault_d = fault_q | {stuck, seq_err, illegal, conflict};
`else
        fault_d = {stuck, seq_err, illegal, conflict};
`endif
        safe_d = |fault_d;
    end

    // Register the sample and its decoded results; reset discards the sample
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            phase_q      <= PH_INVALID;
            prev_light_q <= '0;
            prev_valid_q <= 1'b0;
            dwell_q      <= '0;
            change_q     <= 1'b0;
            fault_q      <= '0;
            safe_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            prev_light_q <= light;
            prev_valid_q <= 1'b1;
            dwell_q      <= dwell_d;
            change_q     <= change_d;
            fault_q      <= fault_d;
            safe_q       <= safe_d;
        end
    end

    assign phase    = phase_q;
    assign dwell    = dwell_q;
    assign change   = change_q;
    assign fault    = fault_q;
    assign safe_red = safe_q;

endmodule

// File: tb/tb_light_monitor.sv
// tb_light_monitor: directed scoreboard bench for light_monitor.
// Each step pushes the expected outputs, drives one sample, and after the
// following rising edge pops the expectation and compares all outputs.
// Honours LIGHT_MONITOR_FAULT_LATCH_EN when computing expected faults.
module tb_light_monitor;

    localparam logic [5:0] NSG = 6'b001100;
    localparam logic [5:0] NSY = 6'b010100;
    localparam logic [5:0] EWG = 6'b100001;
    localparam logic [5:0] EWY = 6'b100010;
    localparam logic [5:0] AR  = 6'b100100;

    logic       clk_1Hz = 1'b0;
    logic       reset;
    logic [5:0] light;
    logic [2:0] phase;
    logic [7:0] dwell;
    logic       change;
    logic [3:0] fault;
    logic       safe_red;

    typedef struct {
        string      tag;
        logic [2:0] ph;
        logic [7:0] dw;
        logic       ch;
        logic [3:0] flt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    logic [3:0]  sticky  = '0;

    light_monitor #(.YEL_MIN(3), .STUCK_MAX(60)) dut (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .light   (light),
        .phase   (phase),
        .dwell   (dwell),
        .change  (change),
        .fault   (fault),
        .safe_red(safe_red)
    );

    // 10 time-unit clock period
    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [5:0] l,
                        input logic [2:0] ph, input logic [7:0] dw, input logic ch,
                        input logic [3:0] f);
        exp_t e;
        logic [3:0] fe;
        if (rst) begin
            sticky = '0;
            fe     = '0;
        end else begin
`ifdef LIGHT_MONITOR_FAULT_LATCH_EN
            sticky = sticky | f;
            fe     = sticky;
`else
            fe     = f;
`endif
        end
        e.tag = tag; e.ph = ph; e.dw = dw; e.ch = ch; e.flt = fe;
        sb.push_back(e);
        reset = rst;
        light = l;
        @(posedge clk_1Hz);
        #1;
        if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s.scoreboard: observed empty required entry", tag);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".phase"},    {5'b0, phase},     {5'b0, e.ph});
            check({e.tag, ".dwell"},    dwell,             e.dw);
            check({e.tag, ".change"},   {7'b0, change},    {7'b0, e.ch});
            check({e.tag, ".fault"},    {4'b0, fault},     {4'b0, e.flt});
            check({e.tag, ".safe_red"}, {7'b0, safe_red},  {7'b0, |e.flt});
        end
    endtask

    initial begin
        logic [7:0] dw;
        reset = 1'b1;
        light = '0;

        // Reset with a conflicting pattern on the bus: sample discarded
        step("reset0", 1'b1, 6'b001001, 3'd7, 8'd0, 1'b0, 4'b0000);

        // Hold NS green for 10 samples; first sample has no predecessor
        for (int i = 0; i < 10; i++)
            step("nsg_hold", 1'b0, NSG, 3'd0, 8'(i), 1'b0, 4'b0000);

        // Full legal cycle with minimum yellow holds
        for (int i = 0; i < 3; i++) step("cyc_nsy", 1'b0, NSY, 3'd1, 8'(i), i == 0, 4'b0000);
        for (int i = 0; i < 5; i++) step("cyc_ewg", 1'b0, EWG, 3'd2, 8'(i), i == 0, 4'b0000);
        for (int i = 0; i < 3; i++) step("cyc_ewy", 1'b0, EWY, 3'd3, 8'(i), i == 0, 4'b0000);
        step("cyc_nsg", 1'b0, NSG, 3'd0, 8'd0, 1'b1, 4'b0000);

        // Short yellow then permitted 1->4: sequence fault from yellow timing
        step("short_y0", 1'b0, NSY, 3'd1, 8'd0, 1'b1, 4'b0000);
        step("short_y1", 1'b0, NSY, 3'd1, 8'd1, 1'b0, 4'b0000);
        step("short_ar", 1'b0, AR,  3'd4, 8'd0, 1'b1, 4'b0100);
        step("after_ar", 1'b0, NSG, 3'd0, 8'd0, 1'b1, 4'b0000);

        // Conflict then illegal; phase-7 transitions never raise sequence
        step("conflict", 1'b0, 6'b001001, 3'd7, 8'd0, 1'b1, 4'b0001);
        step("illegal",  1'b0, 6'b000100, 3'd7, 8'd0, 1'b1, 4'b0010);
        step("from_inv", 1'b0, NSG, 3'd0, 8'd0, 1'b1, 4'b0000);

        // Forbidden 0->2, then forbidden 2->4
        step("bad_0to2", 1'b0, EWG, 3'd2, 8'd0, 1'b1, 4'b0100);
        step("bad_2to4", 1'b0, AR,  3'd4, 8'd0, 1'b1, 4'b0100);

        // Hold all-red: stuck at dwell 60, dwell saturates at 255
        for (int i = 1; i < 260; i++) begin
            dw = (i > 255) ? 8'd255 : 8'(i);
            step("stuck_hold", 1'b0, AR, 3'd4, dw, 1'b0, (dw >= 8'd60) ? 4'b1000 : 4'b0000);
        end

        // Reset mid-phase with stuck fault active
        step("reset_mid", 1'b1, EWG, 3'd7, 8'd0, 1'b0, 4'b0000);
        // 4->1 would be forbidden, but no previous sample exists after reset
        step("post_rst0", 1'b0, NSY, 3'd1, 8'd0, 1'b0, 4'b0000);
        step("post_rst1", 1'b0, NSY, 3'd1, 8'd1, 1'b0, 4'b0000);
        step("yel_short", 1'b0, EWG, 3'd2, 8'd0, 1'b1, 4'b0100);

        // Reset while conflict is flagged
        step("conf_set",  1'b0, 6'b010001, 3'd7, 8'd0, 1'b1, 4'b0001);
        step("reset_cf",  1'b1, 6'b010001, 3'd7, 8'd0, 1'b0, 4'b0000);
        step("post_cf",   1'b0, EWY, 3'd3, 8'd0, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
